sin_core_driver: RTL

Host-side sequencer for the sine core's start/ready handshake. It accepts x operands over a valid/ready stream and buffers them in a small FIFO. For each operand it presents x to the core, pulses `start` for one cycle, tracks the core through busy and back to ready, then captures the result and delivers it over a valid/ack output port. It sits between the test wrapper's stimulus logic and the sine datapath/controller pair, and is the initiator side of the interface the core's controller responds to.

---
 rtl/sin_core_driver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sin_core_driver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sin_core_driver
//
// Host-side sequencer for the sine core's start/ready handshake.
// Operands arrive over a valid/ready stream and are buffered in a small
// circular FIFO. One at a time, each operand is presented to the core on
// core_x, a one-cycle core_start pulse is issued, and the core is followed
// through busy (core_ready low) and back to idle (core_ready high). The
// result is then captured and offered on a valid/ack output port.
//
// Ports:
//   clk          single clock, all state changes on posedge
//   rst          asynchronous active-low reset
//   in_valid     operand offered
//   in_data      operand x (XW bits)
//   in_ready     FIFO not full (from registered count only)
//   core_start   one-cycle start pulse to the core
//   core_x       operand held to the core from issue until completion
//   core_ready   core idle/done indicator
//   core_result  core result, valid while core_ready=1 after completion
//   out_valid    captured result available
//   out_data     captured result (RW bits)
//   out_ack      consumer takes the result when out_valid & out_ack
//   busy         sequencer not in IDLE
//   core_err     sticky flag: core never went busy after a start
//   done_count   completed operations, wraps 255 -> 0
// -----------------------------------------------------------------------------
module sin_core_driver #(
  parameter int XW    = 8,
  parameter int RW    = 16,
  parameter int DEPTH = 4,
  parameter int TMO   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [XW-1:0] in_data,
  output logic          in_ready,
  output logic          core_start,
  output logic [XW-1:0] core_x,
  input  logic          core_ready,
  input  logic [RW-1:0] core_result,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  input  logic          out_ack,
  output logic          busy,
  output logic          core_err,
  output logic [7:0]    done_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t state, next_state;

  logic [XW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tmo_cnt;

  logic push, pop, fifo_empty, tmo_hit, fault, capture;

  // in_ready depends only on the registered count, so a pop on the same
  // edge never opens a slot for a push while the FIFO reads as full.
  assign in_ready   = (count != CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = in_valid & in_ready;
  assign tmo_hit    = (tmo_cnt == TW'(TMO - 1));
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and control decode. A new operand is only issued once the
  // previous result has been taken, so out_data can never be overwritten
  // while the consumer still holds it.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    core_start = 1'b0;
    fault      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && core_ready && !out_valid) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // The core must acknowledge the start by dropping ready; if it
        // stays ready for TMO cycles the operand is abandoned.
        if (!core_ready) begin
          next_state = WAIT_DONE;
        end else if (tmo_hit) begin
          fault      = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_DONE: begin
        if (core_ready) begin
          capture    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FIFO storage; entries need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a
  // power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Operand register: loaded only on the pop edge, so it stays stable from
  // ISSUE through WAIT_DONE and while idling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     core_x <= '0;
    else if (pop) core_x <= mem[rptr];
  end

  // Timeout counter: counts WAIT_BUSY cycles in which the core is still
  // ready, and clears whenever that run is broken or the fault fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tmo_cnt <= '0;
    else if (state == WAIT_BUSY && core_ready && !tmo_hit)
      tmo_cnt <= tmo_cnt + TW'(1);
    else
      tmo_cnt <= '0;
  end

  // Result capture, output handshake and completion counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      done_count <= '0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_data   <= core_result;
      done_count <= done_count + 8'd1;
    end else if (out_ack) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       core_err <= 1'b0;
    else if (fault) core_err <= 1'b1;
  end

endmodule
